traffic_light_monitor: RTL and testbench

Passive checker on the 6-bit `lights` bus produced by the traffic-light controller. It decodes each sampled pattern into a phase and follows the legal phase cycle. It measures dwell time in clock cycles and flags illegal patterns, out-of-order phases and wrong dwell lengths. It sits beside the controller in the top level and in benches. It has no outputs back to the controller.

---
 rtl/traffic_light_monitor.sv | 183 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller's lamp bus: tracks the legal phase cycle.
// Define TLMON_DWELL_CHECK_EN to build the dwell counter with SHORT/LONG checks.
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 15,
  parameter int YEL_CYC    = 3,
  parameter int ALLRED_CYC = 3,
  parameter int TOL        = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [5:0]  lights,
  output logic        locked,
  output logic [2:0]  phase,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  output logic [15:0] cyc_count
);

  localparam logic [5:0] PAT0 = 6'b100001;
  localparam logic [5:0] PAT1 = 6'b100010;
  localparam logic [5:0] PAT2 = 6'b100100;
  localparam logic [5:0] PAT3 = 6'b001100;
  localparam logic [5:0] PAT4 = 6'b010100;

  localparam logic [1:0] E_ILLEGAL = 2'd0;
  localparam logic [1:0] E_SEQ     = 2'd1;

  if (TOL < 0 || TOL >= GREEN_CYC || TOL >= YEL_CYC || TOL >= ALLRED_CYC ||
      GREEN_CYC + TOL > 254 || YEL_CYC + TOL > 254 || ALLRED_CYC + TOL > 254) begin : g_bad_params
    $error("traffic_light_monitor: illegal dwell parameters");
  end

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [5:0]  prev_q;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic        fault;
  logic [1:0]  fcode;
  logic        legal;
  logic [2:0]  succ;

  // P2 and P5 share a lamp pattern; only the predecessor distinguishes them
  function automatic logic [5:0] pat(input logic [2:0] p);
    case (p)
      3'd0:    pat = PAT0;
      3'd1:    pat = PAT1;
      3'd3:    pat = PAT3;
      3'd4:    pat = PAT4;
      default: pat = PAT2;
    endcase
  endfunction

`ifdef TLMON_DWELL_CHECK_EN
  localparam logic [1:0] E_SHORT = 2'd2;
  localparam logic [1:0] E_LONG  = 2'd3;

  logic [7:0] dwell_q, dwell_d, dwell_inc;
  logic       exempt_q, exempt_d;

  function automatic logic [7:0] nom(input logic [2:0] p);
    case (p)
      3'd0, 3'd3: nom = 8'(GREEN_CYC);
      3'd1, 3'd4: nom = 8'(YEL_CYC);
      default:    nom = 8'(ALLRED_CYC);
    endcase
  endfunction

  assign dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
`endif

  assign legal = (lights == PAT0) || (lights == PAT1) || (lights == PAT2) ||
                 (lights == PAT3) || (lights == PAT4);
  assign succ  = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= UNLOCKED;
      phase_q <= '0;
      prev_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      ecnt_q  <= '0;
      cyc_q   <= '0;
`ifdef TLMON_DWELL_CHECK_EN
      dwell_q  <= '0;
      exempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      prev_q  <= lights;
      err_q   <= err_d;
      code_q  <= code_d;
      ecnt_q  <= ecnt_d;
      cyc_q   <= cyc_d;
`ifdef TLMON_DWELL_CHECK_EN
      dwell_q  <= dwell_d;
      exempt_q <= exempt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    err_d   = 1'b0;
    code_d  = code_q;
    ecnt_d  = ecnt_q;
    cyc_d   = cyc_q;
    fault   = 1'b0;
    fcode   = E_ILLEGAL;
`ifdef TLMON_DWELL_CHECK_EN
    dwell_d  = dwell_q;
    exempt_d = exempt_q;
`endif
    if (state_q == LOCKED) begin
      if (lights == prev_q) begin
`ifdef TLMON_DWELL_CHECK_EN
        dwell_d = dwell_inc;
        if (dwell_inc == nom(phase_q) + 8'(TOL) + 8'd1) begin
          fault = 1'b1;
          fcode = E_LONG;
        end
`endif
      end else if (!legal) begin
        fault = 1'b1;
        fcode = E_ILLEGAL;
      end else if (lights != pat(succ)) begin
        fault = 1'b1;
        fcode = E_SEQ;
      end
`ifdef TLMON_DWELL_CHECK_EN
      else if (!exempt_q && dwell_q < nom(phase_q) - 8'(TOL)) begin
        fault = 1'b1;
        fcode = E_SHORT;
      end
`endif
      else begin
        phase_d = succ;
        if (phase_q == 3'd5) cyc_d = cyc_q + 16'd1;
`ifdef TLMON_DWELL_CHECK_EN
        dwell_d  = 8'd1;
        exempt_d = 1'b0;
`endif
      end
    end
    if (fault) begin
      err_d   = 1'b1;
      code_d  = fcode;
      ecnt_d  = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
      state_d = UNLOCKED;
      phase_d = 3'd0;
`ifdef TLMON_DWELL_CHECK_EN
      dwell_d = 8'd0;
`endif
    end
    // the offending sample itself may re-lock; a fresh lock starts a partial, exempt phase
    if ((state_q == UNLOCKED || fault) && lights == PAT0) begin
      state_d = LOCKED;
      phase_d = 3'd0;
`ifdef TLMON_DWELL_CHECK_EN
      dwell_d  = 8'd1;
      exempt_d = 1'b1;
`endif
    end
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    phase     = phase_q;
    err       = err_q;
    err_code  = code_q;
    err_count = ecnt_q;
    cyc_count = cyc_q;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each driven sample queues the expected
// registered response, which is popped and compared on the following falling edge.
module tb_traffic_light_monitor;

  localparam logic [5:0] PAT0 = 6'b100001;
  localparam logic [5:0] PAT1 = 6'b100010;
  localparam logic [5:0] PAT2 = 6'b100100;
  localparam logic [5:0] PAT3 = 6'b001100;
  localparam logic [5:0] PAT4 = 6'b010100;
  localparam logic [5:0] BAD  = 6'b001001;

  logic        clk = 1'b0;
  logic        clr;
  logic [5:0]  lights;
  logic        locked;
  logic [2:0]  phase;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [15:0] cyc_count;

  traffic_light_monitor dut (
    .clk(clk), .clr(clr), .lights(lights), .locked(locked), .phase(phase),
    .err(err), .err_code(err_code), .err_count(err_count), .cyc_count(cyc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic [2:0]  ph;
    logic        er;
    logic [1:0]  code;
    logic [7:0]  cnt;
    logic [15:0] cyc;
    time         t;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  string cur;
  exp_t  me;
  string mnm;
  int    n_chk  = 0;
  int    n_fail = 0;
  logic [1:0]  e_code = 0;
  logic [7:0]  e_cnt  = 0;
  logic [15:0] e_cyc  = 0;

  // drive one sample and queue the response expected one edge later
  task automatic step(input logic [5:0] l, input logic c, input logic lk,
                      input logic [2:0] ph, input logic er, input logic [1:0] code);
    exp_t e;
    lights = l;
    clr    = c;
    if (c) begin
      e_code = 0; e_cnt = 0; e_cyc = 0;
    end else if (er) begin
      e_code = code;
      if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
    end
    e.lk = c ? 1'b0 : lk;
    e.ph = c ? 3'd0 : ph;
    e.er = c ? 1'b0 : er;
    e.code = e_code; e.cnt = e_cnt; e.cyc = e_cyc;
    e.t = $time;
    sb.push_back(e);
    nm_q.push_back(cur);
    @(negedge clk);
  endtask

  task automatic hold(input logic [5:0] l, input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0, 1'b1, ph, 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].t < $time) begin
      me  = sb.pop_front();
      mnm = nm_q.pop_front();
      n_chk++;
      if (locked !== me.lk || (me.lk && phase !== me.ph) || err !== me.er ||
          err_code !== me.code || err_count !== me.cnt || cyc_count !== me.cyc) begin
        n_fail++;
        $display("FAIL %s @%0t: got lk=%0b ph=%0d err=%0b code=%0d cnt=%0d cyc=%0d, expected lk=%0b ph=%0d err=%0b code=%0d cnt=%0d cyc=%0d",
                 mnm, $time, locked, phase, err, err_code, err_count, cyc_count,
                 me.lk, me.ph, me.er, me.code, me.cnt, me.cyc);
      end
    end
  end

  task automatic test_reset();
    cur = "reset";
    step(6'b000000, 1'b1, 0, 0, 0, 0);
    step(6'b000000, 1'b1, 0, 0, 0, 0);
    step(PAT3, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_cycles();
    cur = "cycles";
    for (int k = 0; k < 2; k++) begin
      if (k == 1) e_cyc = e_cyc + 16'd1;
      hold(PAT0, 3'd0, 15);
      hold(PAT1, 3'd1, 3);
      hold(PAT2, 3'd2, 3);
      hold(PAT3, 3'd3, 15);
      hold(PAT4, 3'd4, 3);
      hold(PAT2, 3'd5, 3);
    end
    e_cyc = e_cyc + 16'd1;
    hold(PAT0, 3'd0, 1);
  endtask

  task automatic test_illegal();
    cur = "illegal";
    step(BAD, 1'b0, 0, 0, 1, 2'd0);
    step(BAD, 1'b0, 0, 0, 0, 2'd0);
    step(PAT0, 1'b0, 1, 0, 0, 2'd0);
  endtask

  task automatic test_sequence();
    cur = "sequence";
    step(PAT2, 1'b0, 0, 0, 1, 2'd1);
    step(PAT0, 1'b0, 1, 0, 0, 2'd0);
  endtask

  task automatic test_dwell();
    cur = "dwell";
    hold(PAT0, 3'd0, 14);
    hold(PAT1, 3'd1, 3);
    hold(PAT2, 3'd2, 3);
    hold(PAT3, 3'd3, 15);
`ifdef TLMON_DWELL_CHECK_EN
    step(PAT3, 1'b0, 0, 0, 1, 2'd3);
    step(PAT0, 1'b0, 1, 0, 0, 2'd0);
    hold(PAT1, 3'd1, 2);
    step(PAT2, 1'b0, 0, 0, 1, 2'd2);
`else
    hold(PAT3, 3'd3, 1);
    hold(PAT4, 3'd4, 3);
    hold(PAT2, 3'd5, 3);
    e_cyc = e_cyc + 16'd1;
    hold(PAT0, 3'd0, 1);
    hold(PAT1, 3'd1, 2);
    hold(PAT2, 3'd2, 1);
    step(6'b000000, 1'b0, 0, 0, 1, 2'd0);
`endif
  endtask

  task automatic test_clr_mid();
    cur = "clr_mid";
    hold(PAT0, 3'd0, 15);
    hold(PAT1, 3'd1, 3);
    hold(PAT2, 3'd2, 3);
    hold(PAT3, 3'd3, 5);
    step(PAT3, 1'b1, 0, 0, 0, 0);
    step(PAT3, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    cur = "saturation";
    for (int i = 0; i < 300; i++) begin
      step(PAT0, 1'b0, 1, 0, 0, 2'd0);
      step(BAD,  1'b0, 0, 0, 1, 2'd0);
    end
    n_chk++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_count: err_count=%0d expected 255", err_count);
    end
  endtask

  initial begin
    clr    = 1'b1;
    lights = 6'b000000;
    @(negedge clk);
    test_reset();
    test_cycles();
    test_illegal();
    test_sequence();
    test_dwell();
    test_clr_mid();
    test_saturation();
    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
